i2c_responder: RTL and testbench
================================

I2C_RESPONDER -- requirements
Module: i2c_responder

Interface
REQ-001 SHALL have parameter DEV_ADDR, default 7'h39, the 7-bit I2C target address it acknowledges.
REQ-002 SHALL have port clk, input, 1, the system logic clock; every sequential element is clocked on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset, asynchronous and active-low.
REQ-004 SHALL have port scl_in, input, 1, raw I2C SCL line from the bus.
REQ-005 SHALL have port sda_in, input, 1, raw I2C SDA line from the bus.
REQ-006 SHALL have port sda_oe, output, 1; 1 pulls SDA low, 0 releases it.
REQ-007 SHALL have port wr_en, output, 1, a one-clk pulse per accepted data byte.
REQ-008 SHALL have port wr_addr, output, 8, register index of the current wr_en.
REQ-009 SHALL have port wr_data, output, 8, data byte of the current wr_en.
REQ-010 SHALL have port dbg_addr, input, 8, register-file debug read index.
REQ-011 SHALL have port dbg_data, output, 8, combinational contents of regfile[dbg_addr].
REQ-012 SHALL have port busy, output, 1, high while an addressed transaction is in progress.

Function
REQ-013 SHALL pass scl_in and sda_in through 2-flop synchronizers and then edge detectors; all decisions use the synchronized values.
REQ-014 SHALL detect START as a synchronized SDA fall while SCL is high, and STOP as an SDA rise while SCL is high.
REQ-015 SHALL sample SDA on a detected SCL rise, MSB first, and SHALL change sda_oe only on a detected SCL fall, at most 4 clk after the raw SCL falls.
REQ-016 SHALL use these FSM states: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE.
REQ-017 SHALL move to ADDR on START from any state, including a repeated START; the bit counter clears and the register pointer is retained.
REQ-018 SHALL, after 8 address bits with addr[7:1]==DEV_ADDR, drive the ACK bit low (ADDR_ACK) and then go to PTR if R/W=0, or to RDATA if R/W=1.
REQ-019 SHALL, on an address mismatch (including general call 0x00), leave sda_oe=0 and go to IGNORE until START or STOP.
REQ-020 SHALL load the register pointer from the first write byte (PTR), ACK it, and not issue wr_en for it.
REQ-021 SHALL, for each later write byte, write regfile[ptr], pulse wr_en for exactly 1 clk with wr_addr=ptr and wr_data=byte, ACK the byte, then increment ptr.
REQ-022 SHALL, in RDATA, shift out regfile[ptr] MSB first, driving sda_oe=~bit.
REQ-023 SHALL, in RDATA_ACK, release SDA; a controller ACK (0) increments ptr and continues RDATA, and a controller NACK (1) goes to IGNORE.
REQ-024 SHALL wrap ptr increments 8'hFF→8'h00.
REQ-025 SHALL keep the bit counter 3 bits wide, with byte boundary at count 7.
REQ-026 SHALL, on STOP in any state, go to IDLE with sda_oe=0 and busy=0 on the next clk, and discard any partial byte without a write.
REQ-027 SHALL, when START/STOP and an SCL edge are detected in the same clk, give START/STOP priority.
REQ-028 SHALL assert busy from address match until STOP or mismatch-IGNORE.
REQ-029 SHALL keep the register file at 256x8.

Reset
REQ-030 SHALL, while rst=0, immediately force state=IDLE, sda_oe=0, wr_en=0, wr_addr=0, wr_data=0, busy=0, ptr=0, bit counter=0, and synchronizers to 1.
REQ-031 SHALL reset every register-file entry to 8'h00.
REQ-032 SHALL, after rst deasserts mid-transfer, ignore bus activity until the next START.

Configuration
REQ-033 SHALL, with macro I2C_RESPONDER_READ_EN defined, support reads as in REQ-022/023.
REQ-034 SHALL, with I2C_RESPONDER_READ_EN undefined, NACK a matching address with R/W=1 (go to IGNORE, busy=0) and synthesize no RDATA/RDATA_ACK logic.

Verification
REQ-035 SHALL cover a write: START, 0x72, 0x41, 0x10, STOP -> 3 ACKs; wr_en pulses once with wr_addr=0x41 and wr_data=0x10; dbg_addr=0x41 returns 0x10.
REQ-036 SHALL cover a burst write with wrap: START, 0x72, 0xFF, 0xAA, 0xBB, STOP -> regfile[0xFF]=0xAA and regfile[0x00]=0xBB.
REQ-037 SHALL cover a read after repeated START: 0x72, 0x41, Sr, 0x73, then controller NACK -> SDA carries 0x10 and the responder releases SDA in the ACK slot (READ_EN defined).
REQ-038 SHALL cover an address mismatch: START, 0x74, 0x00 -> sda_oe stays 0 throughout and no wr_en.
REQ-039 SHALL cover STOP after 4 data bits, then rst pulse -> no wr_en, state IDLE, and all outputs at reset values.
REQ-040 SHALL cover a read with READ_EN undefined: START, 0x73 -> NACK (SDA high) on the 9th clock and busy=0.

Source files
------------

// File: rtl/i2c_responder.sv
// rtl/i2c_responder.sv - I2C target with 256x8 register file; define I2C_RESPONDER_READ_EN to enable reads
module i2c_responder #(
  parameter logic [6:0] DEV_ADDR = 7'h39
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic       wr_en,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  input  logic [7:0] dbg_addr,
  output logic [7:0] dbg_data,
  output logic       busy
);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE
  } state_t;

  state_t      state;
  logic        scl_s1, scl_s2, scl_d;
  logic        sda_s1, sda_s2, sda_d;
  logic [1:0]  settle;
  logic [2:0]  cnt;
  logic [6:0]  sh;
  logic [7:0]  ptr;
  logic [7:0]  regfile [256];
`ifdef I2C_RESPONDER_READ_EN
  logic        ack_seen;
`endif

  logic        edges_ok, scl_rise, scl_fall, start_det, stop_det, accept;
  logic [7:0]  full;

  // Edge detection stays masked until the reset-value synchronizers have flushed,
  // so a low SDA at reset release is not mistaken for a START.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scl_s1 <= 1'b1;
      scl_s2 <= 1'b1;
      scl_d  <= 1'b1;
      sda_s1 <= 1'b1;
      sda_s2 <= 1'b1;
      sda_d  <= 1'b1;
      settle <= 2'd0;
    end else begin
      scl_s1 <= scl_in;
      scl_s2 <= scl_s1;
      scl_d  <= scl_s2;
      sda_s1 <= sda_in;
      sda_s2 <= sda_s1;
      sda_d  <= sda_s2;
      if (settle != 2'd3) settle <= settle + 2'd1;
    end
  end

  assign edges_ok  = (settle == 2'd3);
  assign scl_rise  = edges_ok & scl_s2 & ~scl_d;
  assign scl_fall  = edges_ok & ~scl_s2 & scl_d;
  assign start_det = edges_ok & scl_s2 & scl_d & sda_d & ~sda_s2;
  assign stop_det  = edges_ok & scl_s2 & scl_d & ~sda_d & sda_s2;
  assign full      = {sh, sda_s2};

`ifdef I2C_RESPONDER_READ_EN
  assign accept = (full[7:1] == DEV_ADDR);
`else
  assign accept = (full[7:1] == DEV_ADDR) & ~full[0];
`endif

  assign dbg_data = regfile[dbg_addr];

  // ACK states use sda_oe as their phase flag: first SCL fall drives the ACK,
  // the second releases it and moves on.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      sda_oe  <= 1'b0;
      wr_en   <= 1'b0;
      wr_addr <= 8'h00;
      wr_data <= 8'h00;
      busy    <= 1'b0;
      ptr     <= 8'h00;
      cnt     <= 3'd0;
      sh      <= 7'd0;
`ifdef I2C_RESPONDER_READ_EN
      ack_seen <= 1'b0;
`endif
      for (int i = 0; i < 256; i++) regfile[i] <= 8'h00;
    end else begin
      wr_en <= 1'b0;
      if (stop_det) begin
        state  <= IDLE;
        sda_oe <= 1'b0;
        busy   <= 1'b0;
        cnt    <= 3'd0;
      end else if (start_det) begin
        state <= ADDR;
        cnt   <= 3'd0;
      end else begin
        case (state)
          ADDR: begin
            if (scl_rise) begin
              sh  <= full[6:0];
              cnt <= cnt + 3'd1;
              if (cnt == 3'd7) begin
                if (accept) begin
                  state <= ADDR_ACK;
                  busy  <= 1'b1;
                end else begin
                  state <= IGNORE;
                  busy  <= 1'b0;
                end
              end
            end
          end
          ADDR_ACK: begin
            if (scl_fall) begin
              if (!sda_oe) begin
                sda_oe <= 1'b1;
              end else begin
                cnt <= 3'd0;
`ifdef I2C_RESPONDER_READ_EN
                if (sh[0]) begin
                  state  <= RDATA;
                  sh     <= regfile[ptr][6:0];
                  sda_oe <= ~regfile[ptr][7];
                end else begin
                  state  <= PTR;
                  sda_oe <= 1'b0;
                end
`else
                state  <= PTR;
                sda_oe <= 1'b0;
`endif
              end
            end
          end
          PTR: begin
            if (scl_rise) begin
              sh  <= full[6:0];
              cnt <= cnt + 3'd1;
              if (cnt == 3'd7) begin
                ptr   <= full;
                state <= PTR_ACK;
              end
            end
          end
          PTR_ACK: begin
            if (scl_fall) begin
              if (!sda_oe) begin
                sda_oe <= 1'b1;
              end else begin
                sda_oe <= 1'b0;
                cnt    <= 3'd0;
                state  <= WDATA;
              end
            end
          end
          WDATA: begin
            if (scl_rise) begin
              sh  <= full[6:0];
              cnt <= cnt + 3'd1;
              if (cnt == 3'd7) begin
                regfile[ptr] <= full;
                wr_en        <= 1'b1;
                wr_addr      <= ptr;
                wr_data      <= full;
                state        <= WDATA_ACK;
              end
            end
          end
          WDATA_ACK: begin
            if (scl_fall) begin
              if (!sda_oe) begin
                sda_oe <= 1'b1;
              end else begin
                sda_oe <= 1'b0;
                ptr    <= ptr + 8'd1;
                cnt    <= 3'd0;
                state  <= WDATA;
              end
            end
          end
`ifdef I2C_RESPONDER_READ_EN
          RDATA: begin
            if (scl_rise) begin
              cnt <= cnt + 3'd1;
              if (cnt == 3'd7) begin
                state    <= RDATA_ACK;
                ack_seen <= 1'b0;
              end
            end else if (scl_fall) begin
              sda_oe <= ~sh[6];
              sh     <= {sh[5:0], 1'b0};
            end
          end
          RDATA_ACK: begin
            if (scl_rise) begin
              if (sda_s2) begin
                state <= IGNORE;
              end else begin
                ptr      <= ptr + 8'd1;
                ack_seen <= 1'b1;
              end
            end else if (scl_fall) begin
              if (!ack_seen) begin
                sda_oe <= 1'b0;
              end else begin
                state  <= RDATA;
                cnt    <= 3'd0;
                sh     <= regfile[ptr][6:0];
                sda_oe <= ~regfile[ptr][7];
              end
            end
          end
`endif
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_responder.sv
// tb/tb_i2c_responder.sv - directed bench for i2c_responder with write/read scoreboards
module tb_i2c_responder;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       scl = 1'b1;
  logic       sda_drv = 1'b1;
  logic [7:0] dbg_addr = 8'h00;
  logic       sda_line;
  logic       sda_oe, wr_en, busy;
  logic [7:0] wr_addr, wr_data, dbg_data;

  int passed = 0;
  int total  = 0;
  int wr_count = 0;
  logic wr_en_d = 1'b0;
  logic oe_seen = 1'b0;
  logic [15:0] wr_q [$];
  logic [7:0]  rd_q [$];

  always #5 clk = ~clk;

  assign sda_line = sda_drv & ~sda_oe;

  i2c_responder #(.DEV_ADDR(7'h39)) dut (
    .clk      (clk),
    .rst      (rst),
    .scl_in   (scl),
    .sda_in   (sda_line),
    .sda_oe   (sda_oe),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data),
    .busy     (busy)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  always @(negedge clk) begin
    if (sda_oe) oe_seen = 1'b1;
    if (wr_en && wr_en_d) check("wr_pulse_width", 16'd1, 16'd0);
    if (wr_en && !wr_en_d) begin
      wr_count++;
      if (wr_q.size() == 0) check("wr_unexpected", 16'd1, 16'd0);
      else check("wr_event", {wr_addr, wr_data}, wr_q.pop_front());
    end
    wr_en_d = wr_en;
  end

  task automatic i2c_start();
    sda_drv = 1'b1; #80;
    scl = 1'b1;     #100;
    sda_drv = 1'b0; #100;
    scl = 1'b0;     #20;
  endtask

  task automatic i2c_stop();
    sda_drv = 1'b0; #80;
    scl = 1'b1;     #100;
    sda_drv = 1'b1; #100;
  endtask

  task automatic send_bit(input logic b);
    sda_drv = b; #80;
    scl = 1'b1;  #100;
    scl = 1'b0;  #20;
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    sda_drv = 1'b1; #80;
    scl = 1'b1;     #50;
    ack = sda_line; #50;
    scl = 1'b0;     #20;
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] d, output logic slot_oe);
    sda_drv = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      #80; scl = 1'b1;
      #50; d[i] = sda_line;
      #50; scl = 1'b0;
      #20;
    end
    sda_drv = nack; #80;
    scl = 1'b1;     #50;
    slot_oe = sda_oe; #50;
    scl = 1'b0;     #20;
    sda_drv = 1'b1;
  endtask

  initial begin
    logic       a0, a1, a2, a3;
    logic [7:0] rd;
    logic       slot;
    int         wr_snap;

    #52;
    check("rst_sda_oe",  {15'd0, sda_oe}, 16'd0);
    check("rst_wr_en",   {15'd0, wr_en},  16'd0);
    check("rst_wr_addr", {8'd0, wr_addr}, 16'd0);
    check("rst_wr_data", {8'd0, wr_data}, 16'd0);
    check("rst_busy",    {15'd0, busy},   16'd0);
    dbg_addr = 8'h41; #1;
    check("rst_dbg",     {8'd0, dbg_data}, 16'd0);
    rst = 1'b1; #200;

    // single write
    wr_q.push_back({8'h41, 8'h10});
    i2c_start();
    write_byte(8'h72, a0);
    check("wr_busy_active", {15'd0, busy}, 16'd1);
    write_byte(8'h41, a1);
    write_byte(8'h10, a2);
    i2c_stop(); #100;
    check("wr_acks", {13'd0, a0, a1, a2}, 16'd0);
    check("wr_busy_after_stop", {15'd0, busy}, 16'd0);
    dbg_addr = 8'h41; #1;
    check("wr_dbg_41", {8'd0, dbg_data}, 16'h0010);

    // burst write with pointer wrap
    wr_q.push_back({8'hFF, 8'hAA});
    wr_q.push_back({8'h00, 8'hBB});
    i2c_start();
    write_byte(8'h72, a0);
    write_byte(8'hFF, a1);
    write_byte(8'hAA, a2);
    write_byte(8'hBB, a3);
    i2c_stop(); #100;
    check("burst_acks", {12'd0, a0, a1, a2, a3}, 16'd0);
    dbg_addr = 8'hFF; #1;
    check("burst_dbg_ff", {8'd0, dbg_data}, 16'h00AA);
    dbg_addr = 8'h00; #1;
    check("burst_dbg_00", {8'd0, dbg_data}, 16'h00BB);

`ifdef I2C_RESPONDER_READ_EN
    // pointer set, repeated START, read one byte then NACK
    i2c_start();
    write_byte(8'h72, a0);
    write_byte(8'h41, a1);
    i2c_start();
    write_byte(8'h73, a2);
    check("rd_acks", {13'd0, a0, a1, a2}, 16'd0);
    rd_q.push_back(8'h10);
    read_byte(1'b1, rd, slot);
    check("rd_data", {8'd0, rd}, {8'd0, rd_q.pop_front()});
    check("rd_ack_slot_released", {15'd0, slot}, 16'd0);
    i2c_stop(); #100;
`else
    // read request without read support is NACKed
    i2c_start();
    write_byte(8'h73, a0);
    check("rd_disabled_nack", {15'd0, a0}, 16'd1);
    check("rd_disabled_busy", {15'd0, busy}, 16'd0);
    i2c_stop(); #100;
`endif

    // address mismatch
    wr_snap = wr_count;
    oe_seen = 1'b0;
    i2c_start();
    write_byte(8'h74, a0);
    write_byte(8'h00, a1);
    check("mm_nacks", {14'd0, a0, a1}, 16'h0003);
    check("mm_busy", {15'd0, busy}, 16'd0);
    i2c_stop(); #100;
    check("mm_oe_never", {15'd0, oe_seen}, 16'd0);
    check("mm_no_wr", 16'(wr_count - wr_snap), 16'd0);

    // STOP after 4 data bits, then reset pulse
    wr_snap = wr_count;
    i2c_start();
    write_byte(8'h72, a0);
    write_byte(8'h20, a1);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    i2c_stop(); #100;
    check("part_acks", {14'd0, a0, a1}, 16'd0);
    check("part_no_wr", 16'(wr_count - wr_snap), 16'd0);
    check("part_busy", {15'd0, busy}, 16'd0);
    dbg_addr = 8'h20; #1;
    check("part_dbg_20", {8'd0, dbg_data}, 16'd0);
    rst = 1'b0; #20;
    check("rst2_sda_oe",  {15'd0, sda_oe}, 16'd0);
    check("rst2_wr_en",   {15'd0, wr_en},  16'd0);
    check("rst2_wr_addr", {8'd0, wr_addr}, 16'd0);
    check("rst2_wr_data", {8'd0, wr_data}, 16'd0);
    check("rst2_busy",    {15'd0, busy},   16'd0);
    dbg_addr = 8'h41; #1;
    check("rst2_dbg_41",  {8'd0, dbg_data}, 16'd0);
    rst = 1'b1; #200;

    check("wr_queue_drained", 16'(wr_q.size()), 16'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
